// File: rtl/rv_pkg.sv
// Shared RV32I core widths, constants and word/register-index types.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_NUM    = 32;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam word_t     ZERO_WORD = 32'h0;
    localparam reg_addr_t REG_ZERO  = 5'd0;

endpackage : rv_pkg

// File: rtl/regfile_rport.sv
// One combinational read port of the integer register file.
// Optional same-cycle WB->ID bypass when REGFILE_BYPASS_EN is defined.
module regfile_rport
    import rv_pkg::*;
(
    input  logic      rst,
    input  logic      re,
    input  reg_addr_t raddr,
    input  word_t     regs [REG_NUM],
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    output word_t     rdata
);

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit = we && (waddr == raddr);
`else
    // The write triple only feeds the bypass mux, absent in this build.
    logic unused_wr;

    assign unused_wr = ^{we, waddr, wdata};
`endif

    // Reset, disabled port and x0 all force zero ahead of any data source.
    always_comb begin
        rdata = ZERO_WORD;
        if (!rst || !re || (raddr == REG_ZERO)) begin
            rdata = ZERO_WORD;
        end
`ifdef REGFILE_BYPASS_EN
        else if (bypass_hit) begin
            rdata = wdata;
        end
`endif
        else begin
            rdata = regs[raddr];
        end
    end

endmodule : regfile_rport

// File: rtl/regfile.sv
// RV32I integer register file: 32 x 32-bit, one write port, two read ports.
// Build option: REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile
    import rv_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    input  logic      re1,
    input  reg_addr_t raddr1,
    output word_t     rdata1,
    input  logic      re2,
    input  reg_addr_t raddr2,
    output word_t     rdata2
);

    word_t regs_q [REG_NUM];
    word_t regs_d [REG_NUM];

    // Next-state storage; x0 is pinned to zero so writes to it vanish.
    always_comb begin
        for (int i = 0; i < int'(REG_NUM); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != REG_ZERO)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = ZERO_WORD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= ZERO_WORD;
            end
        end else begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    regfile_rport u_rport1 (
        .rst   (rst),
        .re    (re1),
        .raddr (raddr1),
        .regs  (regs_q),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata1)
    );

    regfile_rport u_rport2 (
        .rst   (rst),
        .re    (re2),
        .raddr (raddr2),
        .regs  (regs_q),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata2)
    );

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; honours REGFILE_BYPASS_EN.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    regfile u_dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Present a write on the falling edge, let one rising edge take it, end at the next falling edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        we    = 1'b0;
        waddr = 5'd0;
        wdata = 32'h0;
    endtask

    task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        re1    = e1;
        raddr1 = a1;
        re2    = e2;
        raddr2 = a2;
        #1;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;

        // Reset held 3 cycles with a write attempt and enabled reads.
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'h55555555;
        rd(1'b1, 5'd5, 1'b1, 5'd5);
        check("rst_rd1", rdata1, 32'h0);
        check("rst_rd2", rdata2, 32'h0);
        repeat (3) @(negedge clk);
        we = 1'b0;
        rst = 1'b1;

        for (int i = 1; i < 32; i++) begin
            rd(1'b1, 5'(i), 1'b1, 5'(i));
            check($sformatf("clr_p1_x%0d", i), rdata1, 32'h0);
            check($sformatf("clr_p2_x%0d", i), rdata2, 32'h0);
        end

        // First rising edge after release accepts a write.
        @(negedge clk);
        wr(5'd5, 32'hDEADBEEF);
        rd(1'b1, 5'd5, 1'b0, 5'd0);
        check("wr_x5", rdata1, 32'hDEADBEEF);
        check("re2_off", rdata2, 32'h0);

        // x0 protection, in the write cycle and after.
        rd(1'b1, 5'd0, 1'b1, 5'd0);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        #1;
        check("x0_wcyc_p1", rdata1, 32'h0);
        check("x0_wcyc_p2", rdata2, 32'h0);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("x0_after_p1", rdata1, 32'h0);
        check("x0_after_p2", rdata2, 32'h0);

        // Read enables and dual-port same index.
        wr(5'd7, 32'h12345678);
        rd(1'b0, 5'd7, 1'b1, 5'd7);
        check("x7_re1_off", rdata1, 32'h0);
        check("x7_re2_on", rdata2, 32'h12345678);
        rd(1'b1, 5'd7, 1'b1, 5'd7);
        check("x7_dual_p1", rdata1, 32'h12345678);
        check("x7_dual_p2", rdata2, 32'h12345678);
        rd(1'b1, 5'd5, 1'b1, 5'd7);
        check("x5_hold", rdata1, 32'hDEADBEEF);

        // Same-cycle write/read hazard on x9.
        wr(5'd9, 32'h1);
        rd(1'b0, 5'd0, 1'b1, 5'd9);
        check("x9_old", rdata2, 32'h1);
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x9_same_cyc", rdata2, 32'hA5A5A5A5);
`else
        check("x9_same_cyc", rdata2, 32'h1);
`endif
        check("x9_p1_off", rdata1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("x9_next_cyc", rdata2, 32'hA5A5A5A5);

        // Mid-operation asynchronous reset between edges.
        wr(5'd3, 32'hCAFE0000);
        rd(1'b1, 5'd3, 1'b1, 5'd5);
        check("x3_pre", rdata1, 32'hCAFE0000);
        #2;
        rst = 1'b0;
        #1;
        check("x3_async", rdata1, 32'h0);
        check("x5_async", rdata2, 32'h0);
        @(negedge clk);
        we = 1'b1; waddr = 5'd4; wdata = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        rst = 1'b1;
        rd(1'b1, 5'd3, 1'b1, 5'd4);
        check("x3_post", rdata1, 32'h0);
        check("x4_rst_wr", rdata2, 32'h0);
        rd(1'b1, 5'd7, 1'b1, 5'd9);
        check("x7_post", rdata1, 32'h0);
        check("x9_post", rdata2, 32'h0);

        wr(5'd31, 32'h80000001);
        rd(1'b1, 5'd31, 1'b1, 5'd30);
        check("x31_wr", rdata1, 32'h80000001);
        check("x30_zero", rdata2, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_regfile

// File: doc/regfile.md
# regfile

Integer register file at the end of the writeback path in the 5-stage RV32I core. It holds x0–x31 and accepts one write per cycle from the writeback stage's `wd`/`wreg`/`wdata` triple. It serves two read ports, rs1 and rs2, to the decode stage. An optional same-cycle write-to-read bypass closes the WB→ID hazard without a stall.

## Interface
Parameters:
- none; all widths come from the shared package (`XLEN` = 32, `REG_ADDR_W` = 5, `REG_NUM` = 32)

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-low (0 = in reset)
- `we`  in  1  write enable, driven by writeback `wreg_o`
- `waddr`  in  5  write register index, driven by writeback `wd_o`
- `wdata`  in  32  write data, driven by writeback `wdata_o`
- `re1`  in  1  rs1 read enable
- `raddr1`  in  5  rs1 index
- `rdata1`  out  32  rs1 data
- `re2`  in  1  rs2 read enable
- `raddr2`  in  5  rs2 index
- `rdata2`  out  32  rs2 data

## Operation
- Storage is 32 × 32-bit registers, `regs[0..31]`.
- Write:
  - On the rising `clk` edge with `rst` = 1, `we` = 1 and `waddr` ≠ 0, `regs[waddr]` ← `wdata`.
  - Writes to x0 are discarded silently.
  - With `we` = 0, no register changes.
- Read (combinational), evaluated independently per port n ∈ {1,2}, in priority order:
  1. `rst` = 0 → `rdatan` = 0.
  2. `ren` = 0 → `rdatan` = 0.
  3. `raddrn` = 0 → `rdatan` = 0.
  4. Bypass hit (only with the macro, see Configuration) → `rdatan` = `wdata`.
  5. Otherwise `rdatan` = `regs[raddrn]`.
- Reset:
  - Asserting `rst` low clears all 32 registers asynchronously.
  - While `rst` is low, both read outputs are 0 and writes are blocked.
  - A write presented in the same cycle that `rst` falls is lost.
- Both ports may read the same index in the same cycle; each port returns the same value.

## Timing
- Write latency: a write in cycle N is visible through `regs` from cycle N+1.
- Read latency: 0 cycles (combinational path from address to data). There is no read handshake.
- Bypass:
  - With the bypass, data written in cycle N is visible on a read port in cycle N.
  - Without it, that data is visible from cycle N+1.
- Reset release: the first write is accepted on the first rising edge after `rst` goes high.
- All outputs read 0 during reset and immediately after reset, until written.
- Simultaneous write and read of the same index:
  - With bypass: the read returns the new value.
  - Without bypass: the read returns the old value.
- Simultaneous write of x0 and read of x0: the read returns 0 in both builds.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - A read port with `ren` = 1, `raddrn` ≠ 0, `we` = 1 and `waddr` = `raddrn` returns `wdata` in the same cycle.
  - Write-to-read hazards at distance 3 need no stall.
- Undefined:
  - No bypass mux; reads return only stored values.
  - The hazard unit must stall one cycle on a WB→ID match.

## Structure
- Shared package `rv_pkg` contains:
  - `XLEN` = 32, `REG_ADDR_W` = 5, `REG_NUM` = 32
  - `ZERO_WORD` = 32'h0, `REG_ZERO` = 5'd0
  - typedef `reg_addr_t` (5 bits) and `word_t` (32 bits)
- One sub-module, `regfile_rport`, is instantiated twice.
  - Inputs: `rst`, `re`, `raddr`, the storage array, and the write triple.
  - Output: `rdata`.
  - It contains the priority mux and the bypass logic under `REGFILE_BYPASS_EN`.
- Storage and the write logic live in the top module.

## Test plan
- Reset clear: hold `rst` = 0 for 3 cycles, then release. Read x1–x31 on both ports → all return 32'h0.
- Basic write/read: write x5 = 32'hDEADBEEF in cycle N, then read `raddr1` = 5 in cycle N+1 → `rdata1` = 32'hDEADBEEF.
- x0 protection: write x0 = 32'hFFFFFFFF, then read x0 on both ports → 0 in the write cycle and on all later cycles.
- Read enable and dual port:
  - x7 = 32'h12345678; read it with `re1` = 0, `re2` = 1 → `rdata1` = 0, `rdata2` = 32'h12345678.
  - With both ports on x7 → both return 32'h12345678.
- Same-cycle hazard: x9 holds 32'h1; in one cycle write x9 = 32'hA5A5A5A5 and read x9 on port 2.
  - With `REGFILE_BYPASS_EN`: `rdata2` = 32'hA5A5A5A5 in that cycle.
  - Without it: 32'h1 in that cycle, 32'hA5A5A5A5 in the next.
- Mid-operation reset: write x3 = 32'hCAFE0000, then drop `rst` asynchronously between edges.
  - `rdata1` (on x3) goes to 0 immediately.
  - After release, x3 reads 0, and a write attempted in the reset cycle has no effect.
